// File: rtl/spi_pkg.sv
// Shared SPI definitions: controller state encoding and default field widths
// used by the clock generator, shift register and control block.
package spi_pkg;

  localparam int SPI_DIV_W = 8;
  localparam int SPI_LEN_W = 6;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } spi_state_e;

endpackage

// File: rtl/spi_clkgen.sv
// SPI serial-clock generator. Divides pclk into SCK for one frame of N bits
// and emits per-edge sample/shift strobes for the shift register.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// ST_IDLE   | no frame; sck follows cpol input, waits for start with enable
// ST_ACTIVE | frame running; divider toggles sck until edge 2*N is registered
module spi_clkgen #(
  parameter int DIV_W = spi_pkg::SPI_DIV_W,
  parameter int LEN_W = spi_pkg::SPI_LEN_W
) (
  input  logic             pclk,
  input  logic             sreset,
  input  logic             enable,
  input  logic             start,
  input  logic [DIV_W-1:0] clk_div,
  input  logic [LEN_W-1:0] frame_len,
  input  logic             cpol,
  input  logic             cpha,
  output logic             sck,
  output logic             sample_pulse,
  output logic             shift_pulse,
  output logic             busy,
  output logic             done
);

  import spi_pkg::*;

  spi_state_e       state_q, state_d;
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [LEN_W:0]   edge_cnt_q, edge_cnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             cpol_q, cpol_d;
  logic             cpha_q, cpha_d;
  logic             sck_q, sck_d;
  logic             sample_q, sample_d;
  logic             shift_q, shift_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             div_tc;
  logic             leading;
  logic             last_edge;
  logic [LEN_W-1:0] len_m1;

  // edge_cnt_q holds edges already produced, so the edge about to be
  // registered is edge_cnt_q+1. The final edge 2N is reached when
  // edge_cnt_q == 2N-1 == {N-1, 1}; a zero length wraps N-1 to all ones,
  // giving the 2^LEN_W bit frame without widening the counter.
  assign div_tc    = (div_cnt_q == div_q);
  assign leading   = ~edge_cnt_q[0];
  assign len_m1    = len_q - LEN_W'(1);
  assign last_edge = (edge_cnt_q == {len_m1, 1'b1});

  // Next-state, counter and output decode.
  always_comb begin
    state_d    = state_q;
    div_cnt_d  = div_cnt_q;
    edge_cnt_d = edge_cnt_q;
    div_d      = div_q;
    len_d      = len_q;
    cpol_d     = cpol_q;
    cpha_d     = cpha_q;
    sck_d      = sck_q;
    sample_d   = 1'b0;
    shift_d    = 1'b0;
    busy_d     = busy_q;
    done_d     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        sck_d  = cpol;
        busy_d = 1'b0;
        if (start && enable) begin
          div_d      = clk_div;
          len_d      = frame_len;
          cpol_d     = cpol;
          cpha_d     = cpha;
          div_cnt_d  = '0;
          edge_cnt_d = '0;
          busy_d     = 1'b1;
          state_d    = ST_ACTIVE;
        end
      end

      ST_ACTIVE: begin
        if (!enable) begin
          // Abort: park sck at the frame's idle level, no done, no strobes.
          sck_d   = cpol_q;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else if (div_tc) begin
          div_cnt_d  = '0;
          sck_d      = ~sck_q;
          edge_cnt_d = edge_cnt_q + (LEN_W+1)'(1);
          sample_d   = leading ^ cpha_q;
          shift_d    = ~(leading ^ cpha_q);
          if (last_edge) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end
        end else begin
          div_cnt_d = div_cnt_q + DIV_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge pclk) begin
    if (sreset) begin
      state_q    <= ST_IDLE;
      div_cnt_q  <= '0;
      edge_cnt_q <= '0;
      div_q      <= '0;
      len_q      <= '0;
      cpol_q     <= 1'b0;
      cpha_q     <= 1'b0;
      sck_q      <= 1'b0;
      sample_q   <= 1'b0;
      shift_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_cnt_q  <= div_cnt_d;
      edge_cnt_q <= edge_cnt_d;
      div_q      <= div_d;
      len_q      <= len_d;
      cpol_q     <= cpol_d;
      cpha_q     <= cpha_d;
      sck_q      <= sck_d;
      sample_q   <= sample_d;
      shift_q    <= shift_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign sck          = sck_q;
  assign sample_pulse = sample_q;
  assign shift_pulse  = shift_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule

// File: tb/tb_spi_clkgen.sv
// Bench for spi_clkgen: directed frames plus randomized frames with input
// noise, checked cycle by cycle against an arithmetic timing model.
module tb_spi_clkgen;

  localparam int DIV_W = 8;
  localparam int LEN_W = 6;

  logic             pclk = 1'b0;
  logic             sreset;
  logic             enable;
  logic             start;
  logic [DIV_W-1:0] clk_div;
  logic [LEN_W-1:0] frame_len;
  logic             cpol;
  logic             cpha;
  logic             sck;
  logic             sample_pulse;
  logic             shift_pulse;
  logic             busy;
  logic             done;

  int n_assert = 0;
  int n_fail   = 0;

  spi_clkgen #(.DIV_W(DIV_W), .LEN_W(LEN_W)) dut (
    .pclk         (pclk),
    .sreset       (sreset),
    .enable       (enable),
    .start        (start),
    .clk_div      (clk_div),
    .frame_len    (frame_len),
    .cpol         (cpol),
    .cpha         (cpha),
    .sck          (sck),
    .sample_pulse (sample_pulse),
    .shift_pulse  (shift_pulse),
    .busy         (busy),
    .done         (done)
  );

  always #5 pclk = ~pclk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input int cyc, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s cycle %0d: observed %b expected %b", tag, cyc, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int cyc, input logic e_sck,
                         input logic e_smp, input logic e_shf, input logic e_busy,
                         input logic e_done);
    chk({tag, ".sck"},    cyc, sck,          e_sck);
    chk({tag, ".sample"}, cyc, sample_pulse, e_smp);
    chk({tag, ".shift"},  cyc, shift_pulse,  e_shf);
    chk({tag, ".busy"},   cyc, busy,         e_busy);
    chk({tag, ".done"},   cyc, done,         e_done);
  endtask

  // Called just after a falling edge. Cycle 0 is the cycle in which start is
  // presented; cycle c outputs are checked at the falling edge inside cycle c.
  // Edge k (1..2N) appears at cycle 1+k*(d+1); done at cycle 1+2N*(d+1).
  task automatic run_frame(input int d, input int len, input bit pol, input bit pha,
                           input int abort_at, input int rst_at, input bit noise,
                           input string tag);
    int nbits, per, done_c, stop_c, last_c, q;
    bit is_edge, lead_smp;
    nbits  = (len == 0) ? (1 << LEN_W) : len;
    per    = d + 1;
    done_c = 1 + 2 * nbits * per;
    stop_c = done_c;
    if (abort_at > 0) stop_c = abort_at + 1;
    if (rst_at > 0)   stop_c = rst_at + 1;
    last_c = (rst_at > 0) ? stop_c + 1 : stop_c;

    clk_div   = DIV_W'(d);
    frame_len = LEN_W'(len);
    cpol      = pol;
    cpha      = pha;
    enable    = 1'b1;
    sreset    = 1'b0;
    start     = 1'b1;
    @(posedge pclk);

    for (int c = 1; c <= last_c; c++) begin
      @(negedge pclk);
      if (rst_at > 0 && c == stop_c) begin
        chk_all({tag, ".rst"}, c, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      end else if (rst_at > 0 && c == stop_c + 1) begin
        chk_all({tag, ".post_rst"}, c, pol, 1'b0, 1'b0, 1'b0, 1'b0);
      end else if (abort_at > 0 && c == stop_c) begin
        chk_all({tag, ".abort"}, c, pol, 1'b0, 1'b0, 1'b0, 1'b0);
      end else begin
        q        = (c - 1) / per;
        is_edge  = ((c - 1) % per == 0) && (q >= 1);
        lead_smp = ((q % 2) == 1) != pha;
        chk_all(tag, c, pol ^ q[0], is_edge && lead_smp, is_edge && !lead_smp,
                c < done_c, c == done_c);
      end

      if (c < stop_c) begin
        enable = !(abort_at > 0 && c == abort_at);
        sreset = (rst_at > 0 && c == rst_at);
        if (noise) begin
          start     = 1'($urandom_range(0, 1));
          clk_div   = DIV_W'($urandom_range(0, (1 << DIV_W) - 1));
          frame_len = LEN_W'($urandom_range(0, (1 << LEN_W) - 1));
          cpol      = 1'($urandom_range(0, 1));
          cpha      = 1'($urandom_range(0, 1));
        end else begin
          start = 1'b0;
        end
      end else begin
        enable    = 1'b1;
        sreset    = 1'b0;
        start     = 1'b0;
        clk_div   = DIV_W'(d);
        frame_len = LEN_W'(len);
        cpol      = pol;
        cpha      = pha;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge pclk);
      chk("idle.busy", i, busy, 1'b0);
      chk("idle.done", i, done, 1'b0);
      chk("idle.sck",  i, sck,  cpol);
    end
  endtask

  initial begin
    int  d, len, ab, nb, dc, gap;
    bit  pol, pha;

    sreset    = 1'b1;
    enable    = 1'b0;
    start     = 1'b0;
    cpol      = 1'b0;
    cpha      = 1'b0;
    clk_div   = '0;
    frame_len = '0;
    repeat (2) @(negedge pclk);
    chk_all("reset", 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    sreset = 1'b0;
    enable = 1'b1;
    cpol   = 1'b1;
    @(negedge pclk);
    chk("idle_tracks_cpol1", 0, sck, 1'b1);
    cpol = 1'b0;
    @(negedge pclk);
    chk("idle_tracks_cpol0", 0, sck, 1'b0);

    run_frame(0, 8, 1'b0, 1'b0, 0, 0, 1'b0, "basic");
    idle(2);
    run_frame(3, 1, 1'b1, 1'b1, 0, 0, 1'b0, "div3_mode3");
    idle(2);
    run_frame(0, 0, 1'b0, 1'b0, 0, 0, 1'b0, "maxlen");
    idle(1);
    run_frame(0, 8, 1'b0, 1'b0, 6, 0, 1'b0, "abort");
    run_frame(0, 8, 1'b0, 1'b0, 0, 0, 1'b0, "after_abort");
    idle(1);
    run_frame(0, 8, 1'b0, 1'b0, 0, 0, 1'b1, "b2b_a");
    run_frame(0, 8, 1'b0, 1'b0, 0, 0, 1'b1, "b2b_b");
    idle(1);
    run_frame(2, 5, 1'b1, 1'b0, 0, 5, 1'b0, "midreset");
    idle(1);
    run_frame(5, 3, 1'b1, 1'b0, 0, 0, 1'b1, "noisy_div5");
    idle(1);

    for (int i = 0; i < 24; i++) begin
      d   = $urandom_range(0, 5);
      len = $urandom_range(0, 12);
      pol = 1'($urandom_range(0, 1));
      pha = 1'($urandom_range(0, 1));
      nb  = (len == 0) ? (1 << LEN_W) : len;
      dc  = 1 + 2 * nb * (d + 1);
      ab  = ($urandom_range(0, 4) == 0) ? $urandom_range(1, dc - 1) : 0;
      run_frame(d, len, pol, pha, ab, 0, 1'b1, "rnd");
      gap = $urandom_range(0, 2);
      idle(gap);
    end

    idle(3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
